// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared constants and types for the RV32 fetch stage
package rv32_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_ENCODING     = 32'h0000_0013;

    // One fetched instruction paired with the address it came from
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/rv32_fetch_fifo.sv
// rtl/rv32_fetch_fifo.sv - two-entry FIFO with synchronous clear
module fetch_fifo #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] slot [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic             do_push;
    logic             do_pop;

    // A full FIFO may still accept a push when the head leaves in the same cycle
    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);
    assign head    = slot[rd_ptr];

    // Pointer/occupancy update; clear behaves exactly like reset
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                slot[wr_ptr] <= push_data;
                wr_ptr       <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rv32_fetch_stage.sv
// rtl/rv32_fetch_stage.sv - IF stage: PC, imem request/response pairing, IF/ID register
module rv32_fetch_stage
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR       = NOP_ENCODING,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc
);

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    logic [1:0]   state;
    logic [1:0]   state_next;
    logic [31:0]  pc;
    // Stale responses are not credited, so several redirects in a row can
    // leave more than two of them in flight; four bits is ample headroom.
    logic [3:0]   drop_cnt;
    logic [3:0]   drop_cnt_next;

    logic [1:0]   tag_count;
    logic [31:0]  tag_head;
    logic [1:0]   fifo_count;
    fetch_entry_t skid_head;
    fetch_entry_t paired;

    logic [2:0]   in_use;
    logic         accept;
    logic         rsp_known;
    logic         rsp_drop;
    logic         rsp_pair;
    logic         load_en;
    logic         skid_pop;
    logic         bypass;
    logic         skid_push;

    assign in_use         = {1'b0, tag_count} + {1'b0, fifo_count};
    assign imem_req_valid = !rst && (state != ST_BOOT) && !redirect_valid
                            && (in_use < 3'(MAX_OUTSTANDING));
    assign imem_req_addr  = pc;
    assign accept         = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is a protocol error and is ignored
    assign rsp_known = imem_rsp_valid && ((drop_cnt != 4'd0) || (tag_count != 2'd0));
    assign rsp_drop  = imem_rsp_valid && (drop_cnt != 4'd0);
    assign rsp_pair  = imem_rsp_valid && (drop_cnt == 4'd0) && (tag_count != 2'd0);

    assign paired.pc    = tag_head;
    assign paired.instr = imem_rsp_data;

    // Buffered entries are older than anything arriving now, so they go first
    assign load_en   = !stall || !id_valid;
    assign skid_pop  = load_en && (fifo_count != 2'd0);
    assign bypass    = load_en && (fifo_count == 2'd0) && rsp_pair;
    assign skid_push = rsp_pair && !bypass;

    fetch_fifo #(.WIDTH(32)) u_tag_q (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect_valid),
        .push      (accept),
        .push_data (pc),
        .pop       (rsp_pair),
        .head      (tag_head),
        .count     (tag_count)
    );

    fetch_fifo #(.WIDTH($bits(fetch_entry_t))) u_skid (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect_valid),
        .push      (skid_push),
        .push_data (paired),
        .pop       (skid_pop),
        .head      (skid_head),
        .count     (fifo_count)
    );

    // Everything still in flight at a redirect is stale, minus a response consumed right now
    always_comb begin
        drop_cnt_next = drop_cnt;
        if (redirect_valid) begin
            drop_cnt_next = drop_cnt + {2'b00, tag_count} - {3'b000, rsp_known};
        end else if (rsp_drop) begin
            drop_cnt_next = drop_cnt - 4'd1;
        end
    end

    // BOOT lasts one cycle; FLUSH is held while stale responses remain
    always_comb begin
        state_next = state;
        case (state)
            ST_BOOT:  state_next = ST_RUN;
            ST_RUN:   if (redirect_valid && (drop_cnt_next != 4'd0)) state_next = ST_FLUSH;
            ST_FLUSH: if (drop_cnt_next == 4'd0) state_next = ST_RUN;
            default:  state_next = ST_BOOT;
        endcase
    end

    // Control state, drop counter and PC
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_BOOT;
            drop_cnt <= 4'd0;
            pc       <= RESET_PC;
        end else begin
            state    <= state_next;
            drop_cnt <= drop_cnt_next;
            if (redirect_valid) begin
                pc <= {redirect_pc[31:2], 2'b00};
            end else if (accept) begin
                pc <= pc + 32'd4;
            end
        end
    end

    // IF/ID register: flush beats stall, stall holds, otherwise skid head then bypass
    always_ff @(posedge clk) begin
        if (rst) begin
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
            id_pc    <= 32'd0;
        end else if (redirect_valid) begin
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
        end else if (load_en) begin
            if (fifo_count != 2'd0) begin
                id_valid <= 1'b1;
                id_pc    <= skid_head.pc;
                id_instr <= skid_head.instr;
            end else if (rsp_pair) begin
                id_valid <= 1'b1;
                id_pc    <= paired.pc;
                id_instr <= paired.instr;
            end else begin
                id_valid <= 1'b0;
                id_instr <= NOP_INSTR;
            end
        end
    end

    // Flag responses that arrive with no request outstanding
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(imem_rsp_valid && !rsp_known))
                else $error("rv32_fetch_stage: response with no outstanding request");
        end
    end

endmodule

// File: tb/tb_rv32_fetch_stage.sv
// tb/tb_rv32_fetch_stage.sv - randomized model-checked bench for rv32_fetch_stage
module tb_rv32_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'd0;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;

    always #5 clk = ~clk;

    rv32_fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc          (id_pc)
    );

    localparam logic [31:0] NOP = 32'h0000_0013;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct { logic [31:0] pc; bit stale; } ostd_t;
    typedef struct { logic [31:0] addr; int due; } mreq_t;

    // Reference model: fetch requests still owed by memory, paired words waiting
    // for the decoder, and the decoder-facing register contents.
    logic [31:0] m_pc;
    bit          m_boot;
    ostd_t       m_out[$];
    logic [31:0] m_pend[$];
    bit          m_idv;
    logic [31:0] m_idi;
    logic [31:0] m_idp;

    mreq_t mq[$];
    int    cyc = 0;
    int    lat_min = 1;
    int    lat_max = 1;
    bit          last_req;
    logic [31:0] last_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;
        #1;
        check("req_valid_in_reset", {31'd0, imem_req_valid}, 32'd0);
        @(posedge clk);
        #1;
        m_pc = 32'd0; m_boot = 1'b1; m_out.delete(); m_pend.delete(); mq.delete();
        m_idv = 1'b0; m_idi = NOP; m_idp = 32'd0;
        check("reset_id_valid", {31'd0, id_valid}, 32'd0);
        check("reset_id_instr", id_instr, NOP);
        check("reset_id_pc", id_pc, 32'd0);
    endtask

    // One clock: drive inputs, check the request side, advance the model, check IF/ID
    task automatic cycle(input bit s, input bit rv, input logic [31:0] rpc, input bit rdy);
        bit          exp_req;
        int          live;
        bit          rsp;
        ostd_t       e;
        logic [31:0] pc_old;
        @(negedge clk);
        rst = 1'b0; stall = s; redirect_valid = rv; redirect_pc = rpc; imem_req_ready = rdy;
        imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mq[0].addr);
        end
        #1;
        live = 0;
        foreach (m_out[i]) if (!m_out[i].stale) live++;
        exp_req = !m_boot && !rv && ((live + m_pend.size()) < 2);
        check("req_valid", {31'd0, imem_req_valid}, {31'd0, exp_req});
        if (exp_req) check("req_addr", imem_req_addr, m_pc);
        last_req = imem_req_valid; last_addr = imem_req_addr;

        rsp = imem_rsp_valid;
        pc_old = m_pc;
        e = '{pc: 32'd0, stale: 1'b1};
        if (rsp) begin
            void'(mq.pop_front());
            if (m_out.size() > 0) e = m_out.pop_front();
        end
        if (rv) begin
            foreach (m_out[i]) m_out[i].stale = 1'b1;
            m_pend.delete();
            m_idv = 1'b0; m_idi = NOP;
            m_pc = {rpc[31:2], 2'b00};
        end else begin
            if (rsp && !e.stale) m_pend.push_back(e.pc);
            if (!s || !m_idv) begin
                if (m_pend.size() > 0) begin
                    m_idp = m_pend.pop_front();
                    m_idv = 1'b1; m_idi = mem_word(m_idp);
                end else begin
                    m_idv = 1'b0; m_idi = NOP;
                end
            end
            if (exp_req && rdy) begin
                m_out.push_back('{pc: pc_old, stale: 1'b0});
                mq.push_back('{addr: pc_old, due: cyc + $urandom_range(lat_max, lat_min)});
                m_pc = pc_old + 32'd4;
            end
        end
        m_boot = 1'b0;

        @(posedge clk);
        cyc++;
        #1;
        check("id_valid", {31'd0, id_valid}, {31'd0, m_idv});
        check("id_instr", id_instr, m_idi);
        if (m_idv) check("id_pc", id_pc, m_idp);
    endtask

    initial begin
        bit found;
        // Straight-line fetch with a single-cycle memory
        do_reset();
        cycle(0, 0, 0, 1);
        check("boot_no_req", {31'd0, last_req}, 32'd0);
        cycle(0, 0, 0, 1);
        check("first_req", {31'd0, last_req}, 32'd1);
        check("first_addr", last_addr, 32'h0);
        cycle(0, 0, 0, 1);
        check("first_id_valid", {31'd0, id_valid}, 32'd1);
        check("first_id_pc", id_pc, 32'h0);
        repeat (5) cycle(0, 0, 0, 1);
        check("stream_id_pc", id_pc, 32'h14);

        // Decoder stall: register holds, skid fills, issue stops
        for (int k = 0; k < 4; k++) begin
            cycle(1, 0, 0, 1);
            check("stall_hold_pc", id_pc, 32'h14);
            if (k >= 2) check("stall_no_issue", {31'd0, last_req}, 32'd0);
        end
        cycle(0, 0, 0, 1);
        check("resume_pc0", id_pc, 32'h18);
        cycle(0, 0, 0, 1);
        check("resume_pc1", id_pc, 32'h1C);
        repeat (4) cycle(0, 0, 0, 1);

        // Redirect with two requests outstanding
        lat_min = 2; lat_max = 2;
        repeat (6) cycle(0, 0, 0, 1);
        cycle(0, 1, 32'h100, 1);
        check("redir_id_valid", {31'd0, id_valid}, 32'd0);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            cycle(0, 0, 0, 1);
            if (id_valid) found = 1'b1;
        end
        check("redir_target_seen", {31'd0, found}, 32'd1);
        check("redir_first_pc", id_pc, 32'h100);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            cycle(0, 0, 0, 1);
            if (id_valid) found = 1'b1;
        end
        check("redir_second_pc", id_pc, 32'h104);

        // Memory backpressure
        lat_min = 1; lat_max = 1;
        repeat (3) cycle(0, 0, 0, 0);
        repeat (4) cycle(0, 0, 0, 1);

        // Redirect to a misaligned target while stalled
        cycle(1, 1, 32'h203, 1);
        check("stall_redir_valid", {31'd0, id_valid}, 32'd0);
        cycle(1, 0, 0, 1);
        check("stall_redir_req", {31'd0, last_req}, 32'd1);
        check("stall_redir_addr", last_addr, 32'h200);
        repeat (5) cycle(0, 0, 0, 1);

        // Reset while stale responses are pending
        lat_min = 3; lat_max = 3;
        repeat (4) cycle(1, 0, 0, 1);
        cycle(0, 1, 32'h300, 1);
        do_reset();
        lat_min = 1; lat_max = 1;
        cycle(0, 0, 0, 1);
        check("post_reset_boot", {31'd0, last_req}, 32'd0);
        cycle(0, 0, 0, 1);
        check("post_reset_addr", last_addr, 32'h0);

        // Randomized traffic
        lat_min = 1; lat_max = 4;
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(999) < 3) begin
                do_reset();
            end else begin
                cycle($urandom_range(99) < 30, $urandom_range(99) < 5,
                      $urandom, $urandom_range(99) < 70);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rv32_fetch_stage.md
Name: rv32_fetch_stage

Overview:
IF stage of the RV32 five-stage pipeline, directly upstream of the ID decoder. Owns the PC, issues word requests to instruction memory (valid/ready request channel, in-order response channel), and pairs each returning instruction word with its PC. It also owns the IF/ID pipeline register feeding the decoder. Honors the decoder's load-use stall and flushes on a branch/jump redirect from EX.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.
NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) driven to ID when invalid.
MAX_OUTSTANDING, 2, in-flight request limit; also the skid FIFO depth (fixed at 2 for this revision).

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
stall  in  1  from decoder; 1 = hold IF/ID register.
redirect_valid  in  1  from EX; 1 = branch taken / jump, flush and refetch.
redirect_pc  in  32  target PC; bits [1:0] ignored (forced 0).
imem_req_valid  out  1  fetch request valid.
imem_req_ready  in  1  memory accepts request this cycle.
imem_req_addr  out  32  word-aligned fetch address.
imem_rsp_valid  in  1  response word valid; in order, >=1 cycle after acceptance.
imem_rsp_data  in  32  instruction word.
id_valid  out  1  IF/ID register holds a real instruction.
id_instr  out  32  instruction to decoder; NOP_INSTR when id_valid=0.
id_pc  out  32  PC of id_instr.

Behaviour:
- Reset (rst=1 at edge): pc=RESET_PC, id_valid=0, id_instr=NOP_INSTR, id_pc=0, pc-tag queue, skid FIFO and drop_cnt cleared, state=BOOT. imem_req_valid=0 while rst=1 and in BOOT. Reset mid-operation discards everything. Later responses for pre-reset requests are not protected; the memory is reset with the core.
- FSM: BOOT -> RUN after one cycle. RUN -> FLUSH on redirect with drop_cnt_next>0. FLUSH -> RUN when drop_cnt reaches 0. Redirect in FLUSH reloads drop_cnt.
- Issue: imem_req_valid = state!=BOOT && !redirect_valid && (tag_count + fifo_count) < MAX_OUTSTANDING. imem_req_addr = pc.
- Accept (valid && ready): push pc into the pc-tag queue, then pc <= pc+4. Wraps modulo 2^32, no flag.
- Response pairing:
  - When drop_cnt>0, the response is discarded and drop_cnt decrements.
  - Otherwise, pop the tag and form {pc, instr}.
  - A response with an empty tag queue and drop_cnt=0 is a protocol error. Ignore it; simulation assertion fires.
- IF/ID load, when !stall or !id_valid:
  - If the skid FIFO is non-empty, load its head.
  - Else, if a paired response arrives this cycle, load it directly (bypass). Latency is response cycle t -> id_valid at t+1.
  - Else set id_valid=0 and id_instr=NOP_INSTR.
- A paired response not consumed by bypass is pushed to the skid FIFO. The credit rule guarantees the FIFO never overflows.
- Stall: the IF/ID register holds all fields. Issue continues while credits remain.
- Redirect (priority over stall and everything else) at edge:
  - pc <= {redirect_pc[31:2],2'b00}.
  - id_valid=0, id_instr=NOP_INSTR.
  - Skid FIFO cleared, tag queue cleared.
  - drop_cnt = tag_count minus 1 if a response arrives in the redirect cycle (that response is also dropped).
  - No request is issued in the redirect cycle; the first target request goes out at t+1.
- Simultaneous push and pop on the FIFO or tag queue are both honored. Occupancy is unchanged.

Decomposition:
- Shared package rv32_pkg: NOP_INSTR, RESET_PC default, and the fetch-entry struct {pc[31:0], instr[31:0]}.
- One sub-module, fetch_fifo: a parameterized 2-entry FIFO with sync clear, used for both the pc-tag queue (32b) and the skid buffer (64b).

Test Plan:
1. Reset, ready=1, 1-cycle memory, no stall:
   - addresses issued are 0x0,0x4,0x8,…
   - id_pc follows the same sequence, id_valid=1 from the 3rd cycle after reset release, one instruction per cycle.
2. Stall held 4 cycles mid-stream:
   - id_instr/id_pc unchanged during the stall.
   - Skid FIFO fills to 2 and issue stops.
   - After release, sequence resumes with no skipped or duplicated PCs.
3. Redirect to 0x100 with 2 requests in flight:
   - both stale responses dropped, id_valid=0 for the gap.
   - The next id_pc is 0x100, then 0x104.
4. Backpressure: imem_req_ready=0 for 3 cycles:
   - imem_req_addr stable at the same pc.
   - No tag pushed; pc advances only on acceptance.
5. Redirect to 0x203 asserted while stall=1:
   - flush wins and the issued address is 0x200.
   - id_valid=0 the next cycle.
6. rst asserted with a full FIFO and drop_cnt=1:
   - all outputs return to reset values.
   - The first request after BOOT has address RESET_PC.
